// File: rtl/rdc_sched.sv
// rdc_sched -- round-constant schedule generator.
//
// After a start in IDLE the block presents one set of LANES round constants
// per round. Rounds go from 0 up to max_round, or from max_round down to 0
// when rev=1 (decrypt order). The consumer pulls the next set by raising
// advance. All outputs are registered.
//
// Handshake: a constant set is transferred on a rising edge where
// rdc_valid=1 and advance=1. rdc, cur_round and rdc_valid stay stable until
// that transfer happens. advance carries no meaning while rdc_valid=0.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   start      begin a schedule (only looked at in IDLE)
//   alg_mode   0 spn8, 1 spn16, 2 spn32, 3 warx, 4 spn24, 5 yoroi16,
//              6 yoroi32, 7 illegal
//   rev        1 = rounds counted downward
//   max_round  index of the last round, inclusive
//   advance    consumer accepts the current constant set
//   rdc        lane i at bits [i*N +: N]
//   rdc_valid  rdc holds the constants for cur_round
//   cur_round  round index of the presented constants
//   busy       high in RUN and DONE
//   done       one-cycle pulse after the last set is accepted
//   mode_err   one-cycle pulse on start with alg_mode 7
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// LANES is expected to be a multiple of 4 in the range 4..32.
module rdc_sched #(
  parameter int N     = 8,
  parameter int LANES = 16,
  parameter int RW    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         alg_mode,
  input  logic               rev,
  input  logic [RW-1:0]      max_round,
  input  logic               advance,
  output logic [LANES*N-1:0] rdc,
  output logic               rdc_valid,
  output logic [RW-1:0]      cur_round,
  output logic               busy,
  output logic               done,
  output logic               mode_err,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] M_SPN8    = 3'd0;
  localparam logic [2:0] M_SPN16   = 3'd1;
  localparam logic [2:0] M_SPN32   = 3'd2;
  localparam logic [2:0] M_WARX    = 3'd3;
  localparam logic [2:0] M_SPN24   = 3'd4;
  localparam logic [2:0] M_YOROI16 = 3'd5;
  localparam logic [2:0] M_YOROI32 = 3'd6;
  localparam logic [2:0] M_ILLEGAL = 3'd7;

  // Lane arithmetic is done at least 32 bits wide and then truncated to N,
  // which gives the modulo 2^N wrap.
  localparam int VW = (N > 32) ? N : 32;

  state_t             state, state_nxt;
  logic [LANES*N-1:0] rdc_nxt;
  logic               valid_nxt;
  logic [RW-1:0]      round_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               err_nxt;
  logic               load_set;
  logic               last_round;

  // Schedule parameters captured at start. Later changes on the inputs are
  // ignored until the next start.
  logic [2:0]         mode_q, mode_nxt;
  logic               rev_q, rev_nxt;
  logic [RW-1:0]      max_q, max_nxt;

  // Constant set for mode m at round r. Active lanes get r*S + k + 1, where
  // k is the lane's rank among the active lanes and S is the number of
  // active lanes. Yoroi modes only put r+1 in their active lanes.
  function automatic logic [LANES*N-1:0] rdc_fn(input logic [2:0]    m,
                                                input logic [RW-1:0] r);
    logic [LANES*N-1:0] v;
    logic [VW-1:0]      rv;
    logic [VW-1:0]      kv;
    logic [VW-1:0]      sv;
    logic               act;
    logic               yoroi;
    v     = '0;
    rv    = VW'(r);
    yoroi = (m == M_YOROI16) || (m == M_YOROI32);
    for (int i = 0; i < LANES; i++) begin
      act = 1'b0;
      kv  = '0;
      sv  = '0;
      case (m)
        M_SPN8: begin
          act = 1'b1;
          kv  = VW'(i);
          sv  = VW'(LANES);
        end
        M_SPN16, M_WARX, M_YOROI16: begin
          act = ((i % 2) == 0);
          kv  = VW'(i / 2);
          sv  = VW'(LANES / 2);
        end
        M_SPN32, M_YOROI32: begin
          act = ((i % 4) == 0);
          kv  = VW'(i / 4);
          sv  = VW'(LANES / 4);
        end
        M_SPN24: begin
          // The last group of three must fit inside the lane array.
          act = ((i % 3) == 0) && ((i + 3) <= LANES);
          kv  = VW'(i / 3);
          sv  = VW'(LANES / 3);
        end
        default: act = 1'b0;
      endcase
      if (act) begin
        if (yoroi) v[i*N +: N] = N'(rv + VW'(1));
        else       v[i*N +: N] = N'(rv * sv + kv + VW'(1));
      end
    end
    return v;
  endfunction

  assign state_dbg  = state;
  assign last_round = rev_q ? (cur_round == '0) : (cur_round == max_q);

  always_comb begin
    state_nxt = state;
    rdc_nxt   = rdc;
    valid_nxt = rdc_valid;
    round_nxt = cur_round;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    mode_nxt  = mode_q;
    rev_nxt   = rev_q;
    max_nxt   = max_q;
    load_set  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (alg_mode == M_ILLEGAL) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = S_RUN;
            mode_nxt  = alg_mode;
            rev_nxt   = rev;
            max_nxt   = max_round;
            round_nxt = rev ? max_round : '0;
            valid_nxt = 1'b1;
            load_set  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (advance) begin
          if (last_round) begin
            // cur_round keeps its final value after the schedule ends.
            state_nxt = S_DONE;
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
            rdc_nxt   = '0;
          end else begin
            round_nxt = rev_q ? (cur_round - RW'(1)) : (cur_round + RW'(1));
            load_set  = 1'b1;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // A single constant generator serves both the start load and the
    // per-round update; mode_nxt already selects the right mode for each.
    if (load_set) rdc_nxt = rdc_fn(mode_nxt, round_nxt);

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rdc       <= '0;
      rdc_valid <= 1'b0;
      cur_round <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mode_err  <= 1'b0;
      mode_q    <= '0;
      rev_q     <= 1'b0;
      max_q     <= '0;
    end else begin
      state     <= state_nxt;
      rdc       <= rdc_nxt;
      rdc_valid <= valid_nxt;
      cur_round <= round_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      mode_err  <= err_nxt;
      mode_q    <= mode_nxt;
      rev_q     <= rev_nxt;
      max_q     <= max_nxt;
    end
  end

endmodule

// File: tb/tb_rdc_sched.sv
// Testbench for rdc_sched. It runs directed scenarios with hand-computed
// lane values, then randomized traffic. A behavioural reference model
// built from the output rules is compared against the DUT on every cycle.
module tb_rdc_sched;
  localparam int N     = 8;
  localparam int LANES = 16;
  localparam int RW    = 4;
  localparam int W     = LANES * N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [2:0]    alg_mode;
  logic          rev;
  logic [RW-1:0] max_round;
  logic          advance;
  logic [W-1:0]  rdc;
  logic          rdc_valid;
  logic [RW-1:0] cur_round;
  logic          busy;
  logic          done;
  logic          mode_err;
  logic [1:0]    state_dbg;

  rdc_sched #(.N(N), .LANES(LANES), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alg_mode(alg_mode),
    .rev(rev), .max_round(max_round), .advance(advance), .rdc(rdc),
    .rdc_valid(rdc_valid), .cur_round(cur_round), .busy(busy),
    .done(done), .mode_err(mode_err), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] lane(input logic [W-1:0] v, input int i);
    return v[i*N +: N];
  endfunction

  // ---------------- reference model ----------------
  // Builds the list of active lanes for a mode. S is the size of that list
  // and k is the position inside it.
  function automatic logic [W-1:0] model_rdc(input int mode, input int r);
    int act[$];
    logic [W-1:0] res;
    logic [31:0]  val;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      case (mode)
        0:       act.push_back(i);
        1, 3, 5: if (i % 2 == 0) act.push_back(i);
        2, 6:    if (i % 4 == 0) act.push_back(i);
        4:       if (i % 3 == 0 && i + 3 <= LANES) act.push_back(i);
        default: ;
      endcase
    end
    for (int k = 0; k < act.size(); k++) begin
      if (mode == 5 || mode == 6) val = r + 1;
      else                        val = r * act.size() + k + 1;
      res[act[k]*N +: N] = val[N-1:0];
    end
    return res;
  endfunction

  logic         e_busy = 1'b0, e_valid = 1'b0, e_done = 1'b0, e_err = 1'b0;
  int           e_round = 0;
  logic [W-1:0] e_rdc = '0;
  int           l_mode = 0, l_max = 0;
  logic         l_rev = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      e_busy = 0; e_valid = 0; e_done = 0; e_err = 0; e_round = 0;
      e_rdc = '0; l_mode = 0; l_rev = 0; l_max = 0;
    end else begin
      e_done = 0;
      e_err  = 0;
      if (!e_busy) begin
        if (start) begin
          if (alg_mode == 3'd7) e_err = 1;
          else begin
            l_mode = alg_mode; l_rev = rev; l_max = max_round;
            e_round = rev ? int'(max_round) : 0;
            e_busy = 1; e_valid = 1;
          end
        end
      end else if (!e_valid) begin
        e_busy = 0;
      end else if (advance) begin
        if (l_rev ? (e_round == 0) : (e_round == l_max)) begin
          e_valid = 0; e_done = 1;
        end else begin
          e_round = l_rev ? e_round - 1 : e_round + 1;
        end
      end
      e_rdc = e_valid ? model_rdc(l_mode, e_round) : '0;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    check("rdc", rdc, e_rdc);
    check("rdc_valid", W'(rdc_valid), W'(e_valid));
    check("cur_round", W'(cur_round), W'(e_round));
    check("busy", W'(busy), W'(e_busy));
    check("done", W'(done), W'(e_done));
    check("mode_err", W'(mode_err), W'(e_err));
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic begin_run(input logic [2:0] m, input logic r,
                           input logic [RW-1:0] mx, input logic adv);
    alg_mode = m; rev = r; max_round = mx; advance = adv; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  vcnt;
    logic hit;
    rst_n = 1'b0; start = 1'b0; alg_mode = '0; rev = 1'b0;
    max_round = '0; advance = 1'b0;
    repeat (2) cyc();
    check("reset_rdc", rdc, '0);
    check("reset_valid", W'(rdc_valid), '0);
    check("reset_busy", W'(busy), '0);
    check("reset_round", W'(cur_round), '0);
    rst_n = 1'b1;
    cyc();

    // spn8, ascending, three rounds with advance held high
    begin_run(3'd0, 1'b0, 4'd2, 1'b1);
    vcnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (rdc_valid) vcnt++;
      if (c == 1) begin
        check("s1_round1", W'(cur_round), W'(1));
        check("s1_lane0", W'(lane(rdc, 0)), W'(17));
        check("s1_lane15", W'(lane(rdc, 15)), W'(32));
      end
      if (c == 3) begin
        check("s1_done", W'(done), W'(1));
        check("s1_busy_in_done", W'(busy), W'(1));
      end
      if (c == 4) check("s1_busy_after", W'(busy), W'(0));
      cyc();
    end
    check("s1_valid_cycles", W'(vcnt), W'(3));

    // spn24, descending; inputs scrambled after latching
    begin_run(3'd4, 1'b1, 4'd3, 1'b0);
    alg_mode = 3'd0; rev = 1'b0; max_round = 4'd9;
    check("s2_round", W'(cur_round), W'(3));
    check("s2_lane0", W'(lane(rdc, 0)), W'(16));
    check("s2_lane3", W'(lane(rdc, 3)), W'(17));
    check("s2_lane12", W'(lane(rdc, 12)), W'(20));
    check("s2_lane1", W'(lane(rdc, 1)), W'(0));
    check("s2_lane15", W'(lane(rdc, 15)), W'(0));
    advance = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      check("s2_seq", W'(cur_round), W'(2 - c));
    end
    cyc();
    check("s2_done", W'(done), W'(1));
    cyc();

    // yoroi16 with advance toggling
    begin_run(3'd5, 1'b0, 4'd5, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rdc_valid && cur_round == 4'd5 && !hit) begin
        hit = 1'b1;
        check("s3_lane4", W'(lane(rdc, 4)), W'(6));
        check("s3_lane5", W'(lane(rdc, 5)), W'(0));
        check("s3_lane10", W'(lane(rdc, 10)), W'(6));
      end
      advance = (c % 2 == 1);
      cyc();
    end
    check("s3_reached_round5", W'(hit), W'(1));
    advance = 1'b0;

    // illegal mode, then a normal spn16 run
    begin_run(3'd7, 1'b0, 4'd3, 1'b0);
    check("s4_mode_err", W'(mode_err), W'(1));
    check("s4_busy", W'(busy), W'(0));
    check("s4_valid", W'(rdc_valid), W'(0));
    begin_run(3'd1, 1'b0, 4'd3, 1'b0);
    check("s4_err_cleared", W'(mode_err), W'(0));
    check("s4_lane2", W'(lane(rdc, 2)), W'(2));
    check("s4_valid_run", W'(rdc_valid), W'(1));
    advance = 1'b1;
    repeat (6) cyc();

    // spn8 to round 15: wrap at 256
    begin_run(3'd0, 1'b0, 4'd15, 1'b1);
    repeat (15) cyc();
    check("s5_round15", W'(cur_round), W'(15));
    check("s5_lane15", W'(lane(rdc, 15)), W'(0));
    check("s5_lane14", W'(lane(rdc, 14)), W'(255));
    repeat (2) cyc();

    // reset mid-run with a simultaneous start
    begin_run(3'd0, 1'b0, 4'd7, 1'b1);
    repeat (2) cyc();
    check("s6_round2", W'(cur_round), W'(2));
    rst_n = 1'b0; start = 1'b1;
    cyc();
    check("s6_rdc", rdc, '0);
    check("s6_valid", W'(rdc_valid), W'(0));
    check("s6_round", W'(cur_round), W'(0));
    check("s6_busy", W'(busy), W'(0));
    check("s6_done", W'(done), W'(0));
    rst_n = 1'b1; start = 1'b0;
    cyc();
    check("s6_no_done", W'(done), W'(0));
    check("s6_idle", W'(busy), W'(0));

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      start     = ($urandom_range(0, 3) == 0);
      alg_mode  = 3'($urandom_range(0, 7));
      rev       = 1'($urandom_range(0, 1));
      max_round = ($urandom_range(0, 1) == 0) ? RW'($urandom_range(0, 3))
                                              : RW'($urandom_range(0, 15));
      advance   = ($urandom_range(0, 2) != 0);
      cyc();
    end
    rst_n = 1'b1; start = 1'b0; advance = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
